// File: rtl/perf_stat_display_pkg.sv
// Shared definitions for the perf-stat display: view codes and 7-seg glyphs.
// Glyphs are active-low {g,f,e,d,c,b,a}; SEG_OFF blanks a digit including dp.
package perf_stat_display_pkg;

    typedef enum logic [2:0] {
        VIEW_MEM = 3'b000,
        VIEW_PC  = 3'b001,
        VIEW_CYC = 3'b010,
        VIEW_CBR = 3'b011,
        VIEW_CTK = 3'b100,
        VIEW_UNC = 3'b101
    } view_e;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    localparam logic [6:0] SEG_GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/perf_stat_display_seg7_hex_decoder.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg7_hex_decoder
    import perf_stat_display_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_GLYPH[nib_i];

endmodule

// File: rtl/perf_stat_display.sv
// Cycle/branch statistic counters plus a scanned 8-digit hex 7-seg display.
module perf_stat_display
    import perf_stat_display_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int SCAN_DIV = 100000,
    parameter int DIGITS   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        halt,
    input  logic        stat_clr,
    input  logic [31:0] pc_in,
    input  logic [31:0] mem_data,
    input  logic        ev_valid,
    input  logic        ev_cond_br,
    input  logic        ev_cond_tk,
    input  logic        ev_uncond,
    input  logic [2:0]  view_sel,
    output logic [7:0]  seg_an,
    output logic [7:0]  seg_cat
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [2:0] DIG_LAST = 3'(DIGITS - 1);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] cbr_q, cbr_d;
    logic [CNT_W-1:0] ctk_q, ctk_d;
    logic [CNT_W-1:0] unc_q, unc_d;
    logic [31:0]      disp_val_q, disp_val_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [2:0]       dig_idx_q, dig_idx_d;
    logic [7:0]       seg_an_q, seg_an_d;
    logic [7:0]       seg_cat_q, seg_cat_d;
    logic [6:0]       glyph;

    logic br_ev, tk_ev, un_ev;

    assign br_ev = ev_valid & ev_cond_br;
    assign tk_ev = br_ev & ev_cond_tk;
    assign un_ev = ev_valid & ev_uncond;

    // Saturating counters; clear has priority over halt and events
    always_comb begin
        cyc_d = cyc_q;
        cbr_d = cbr_q;
        ctk_d = ctk_q;
        unc_d = unc_q;
        if (stat_clr) begin
            cyc_d = '0;
            cbr_d = '0;
            ctk_d = '0;
            unc_d = '0;
        end else if (!halt) begin
            if (!(&cyc_q))         cyc_d = cyc_q + ONE;
            if (br_ev && !(&cbr_q)) cbr_d = cbr_q + ONE;
            if (tk_ev && !(&ctk_q)) ctk_d = ctk_q + ONE;
            if (un_ev && !(&unc_q)) unc_d = unc_q + ONE;
        end
    end

    always_comb begin
        disp_val_d = '0;
        case (view_sel)
            VIEW_MEM: disp_val_d = mem_data;
            VIEW_PC:  disp_val_d = pc_in;
            VIEW_CYC: disp_val_d = 32'(cyc_q);
            VIEW_CBR: disp_val_d = 32'(cbr_q);
            VIEW_CTK: disp_val_d = 32'(ctk_q);
            VIEW_UNC: disp_val_d = 32'(unc_q);
            default:  disp_val_d = '0;
        endcase
    end

    seg7_hex_decoder u_dec (
        .nib_i (disp_val_q[{dig_idx_q, 2'b00} +: 4]),
        .seg_o (glyph)
    );

    always_comb begin
        div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DIV_W'(1);
        dig_idx_d = dig_idx_q;
        if (div_cnt_q == DIV_LAST) begin
            dig_idx_d = (dig_idx_q == DIG_LAST) ? 3'd0 : dig_idx_q + 3'd1;
        end
        seg_an_d            = SEG_OFF;
        seg_an_d[dig_idx_q] = 1'b0;
        seg_cat_d           = {1'b1, glyph};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q      <= '0;
            cbr_q      <= '0;
            ctk_q      <= '0;
            unc_q      <= '0;
            disp_val_q <= '0;
            div_cnt_q  <= '0;
            dig_idx_q  <= '0;
            seg_an_q   <= 8'hFE;
            seg_cat_q  <= 8'hC0;
        end else begin
            cyc_q      <= cyc_d;
            cbr_q      <= cbr_d;
            ctk_q      <= ctk_d;
            unc_q      <= unc_d;
            disp_val_q <= disp_val_d;
            div_cnt_q  <= div_cnt_d;
            dig_idx_q  <= dig_idx_d;
            seg_an_q   <= seg_an_d;
            seg_cat_q  <= seg_cat_d;
        end
    end

    assign seg_an  = seg_an_q;
    assign seg_cat = seg_cat_q;

endmodule

// File: tb/tb_perf_stat_display.sv
// Bench for perf_stat_display: a 32-bit and a 4-bit-counter instance share stimulus.
module tb_perf_stat_display;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        halt, stat_clr;
    logic [31:0] pc_in, mem_data;
    logic        ev_valid, ev_cond_br, ev_cond_tk, ev_uncond;
    logic [2:0]  view_sel;
    logic [7:0]  an0, cat0, an1, cat1;

    int passed = 0;
    int total  = 0;

    logic [6:0] gl [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // reference counts: index 0 = 32-bit instance, 1 = 4-bit instance
    longint m_cyc [2], m_cbr [2], m_ctk [2], m_unc [2];
    longint m_max [2] = '{64'hFFFF_FFFF, 64'hF};

    always #5 clk = ~clk;

    perf_stat_display #(.CNT_W(32), .SCAN_DIV(4), .DIGITS(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .halt(halt), .stat_clr(stat_clr),
        .pc_in(pc_in), .mem_data(mem_data), .ev_valid(ev_valid),
        .ev_cond_br(ev_cond_br), .ev_cond_tk(ev_cond_tk),
        .ev_uncond(ev_uncond), .view_sel(view_sel),
        .seg_an(an0), .seg_cat(cat0)
    );

    perf_stat_display #(.CNT_W(4), .SCAN_DIV(4), .DIGITS(8)) u_sat (
        .clk(clk), .rst_n(rst_n), .halt(halt), .stat_clr(stat_clr),
        .pc_in(pc_in), .mem_data(mem_data), .ev_valid(ev_valid),
        .ev_cond_br(ev_cond_br), .ev_cond_tk(ev_cond_tk),
        .ev_uncond(ev_uncond), .view_sel(view_sel),
        .seg_an(an1), .seg_cat(cat1)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic longint bump(longint v, longint mx, bit en);
        if (!en) return v;
        return (v >= mx) ? mx : v + 1;
    endfunction

    task automatic model_zero();
        for (int k = 0; k < 2; k++) begin
            m_cyc[k] = 0; m_cbr[k] = 0; m_ctk[k] = 0; m_unc[k] = 0;
        end
    endtask

    task automatic tick();
        bit br, tk, un;
        br = ev_valid && ev_cond_br;
        tk = br && ev_cond_tk;
        un = ev_valid && ev_uncond;
        for (int k = 0; k < 2; k++) begin
            if (stat_clr) begin
                m_cyc[k] = 0; m_cbr[k] = 0; m_ctk[k] = 0; m_unc[k] = 0;
            end else if (!halt) begin
                m_cyc[k] = bump(m_cyc[k], m_max[k], 1'b1);
                m_cbr[k] = bump(m_cbr[k], m_max[k], br);
                m_ctk[k] = bump(m_ctk[k], m_max[k], tk);
                m_unc[k] = bump(m_unc[k], m_max[k], un);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit h, input bit c, input bit v,
                         input bit b, input bit t, input bit u);
        halt = h; stat_clr = c; ev_valid = v;
        ev_cond_br = b; ev_cond_tk = t; ev_uncond = u;
    endtask

    function automatic logic [31:0] expv(int k, logic [2:0] v);
        case (v)
            3'd0: return mem_data;
            3'd1: return pc_in;
            3'd2: return 32'(m_cyc[k]);
            3'd3: return 32'(m_cbr[k]);
            3'd4: return 32'(m_ctk[k]);
            3'd5: return 32'(m_unc[k]);
            default: return 32'h0;
        endcase
    endfunction

    // freeze counters, then reconstruct the shown value from the scanned digits
    task automatic read_disp(input int k, input logic [2:0] v,
                             output logic [31:0] val);
        logic [7:0] seen;
        logic [7:0] an, cat;
        bit bad;
        drive(1, 0, 0, 0, 0, 0);
        view_sel = v;
        val = '0; seen = '0; bad = 0;
        tick(); tick();
        for (int n = 0; n < 48 && seen != 8'hFF; n++) begin
            an  = k ? an1 : an0;
            cat = k ? cat1 : cat0;
            for (int i = 0; i < 8; i++) begin
                if (an == ~(8'd1 << i)) begin
                    bit hit = 0;
                    for (int j = 0; j < 16; j++) begin
                        if (cat == {1'b1, gl[j]}) begin
                            val[4*i +: 4] = 4'(j);
                            hit = 1;
                        end
                    end
                    if (!hit) bad = 1;
                    seen[i] = 1'b1;
                end
            end
            tick();
        end
        chk("read_complete", {23'd0, bad, seen}, 32'h0000_00FF);
    endtask

    task automatic chk_view(input string tag, input int k,
                            input logic [2:0] v);
        logic [31:0] got;
        read_disp(k, v, got);
        chk(tag, got, expv(k, v));
    endtask

    initial begin
        logic [31:0] got;
        int prev, run, idx;
        bit seen_chg, wrapped;

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        pc_in = 32'h0; mem_data = 32'h0; view_sel = 3'd2;
        model_zero();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_an", {24'd0, an0}, 32'hFE);
        chk("rst_cat", {24'd0, cat0}, 32'hC0);
        rst_n = 1'b1;

        for (int v = 2; v <= 5; v++) begin
            read_disp(0, 3'(v), got);
            chk("rst_ctr", got, 32'h0);
        end

        drive(0, 0, 0, 0, 0, 0);
        repeat (10) tick();
        drive(1, 0, 0, 0, 0, 0);
        repeat (5) tick();
        read_disp(0, 3'd2, got);
        chk("halt_cyc", got, 32'h0000_000A);
        drive(0, 0, 0, 0, 0, 0);
        tick();
        read_disp(0, 3'd2, got);
        chk("resume_cyc", got, 32'h0000_000B);

        drive(1, 1, 0, 0, 0, 0);
        tick();
        for (int i = 0; i < 3; i++) begin drive(0, 0, 1, 1, 1, 0); tick(); end
        for (int i = 0; i < 2; i++) begin drive(0, 0, 1, 1, 0, 0); tick(); end
        drive(0, 0, 0, 1, 1, 0); tick();
        for (int i = 0; i < 4; i++) begin drive(0, 0, 1, 0, 0, 1); tick(); end
        read_disp(0, 3'd3, got); chk("ev_cbr", got, 32'd5);
        read_disp(0, 3'd4, got); chk("ev_ctk", got, 32'd3);
        read_disp(0, 3'd5, got); chk("ev_unc", got, 32'd4);
        read_disp(0, 3'd2, got); chk("ev_cyc", got, 32'd10);

        drive(1, 1, 0, 0, 0, 0);
        tick();
        drive(0, 0, 1, 1, 1, 1);
        repeat (20) tick();
        read_disp(1, 3'd2, got); chk("sat_cyc", got, 32'h0000_000F);
        read_disp(1, 3'd3, got); chk("sat_cbr", got, 32'h0000_000F);
        read_disp(0, 3'd2, got); chk("wide_cyc", got, 32'd20);
        drive(0, 0, 0, 0, 0, 0);
        repeat (5) tick();
        read_disp(1, 3'd2, got); chk("sat_stay", got, 32'h0000_000F);
        drive(1, 1, 1, 1, 1, 1);
        tick();
        read_disp(1, 3'd2, got); chk("clr_cyc", got, 32'h0);
        read_disp(1, 3'd4, got); chk("clr_ctk", got, 32'h0);
        read_disp(0, 3'd3, got); chk("clr_cbr", got, 32'h0);

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 150; i++) begin
                drive($urandom_range(0, 4) == 0, $urandom_range(0, 60) == 0,
                      1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
                tick();
            end
            pc_in = $urandom;
            mem_data = $urandom;
            for (int k = 0; k < 2; k++) begin
                for (int v = 0; v <= 7; v++) chk_view("rand_view", k, 3'(v));
            end
        end

        drive(0, 0, 0, 0, 0, 0);
        view_sel = 3'd1;
        pc_in = 32'h1234_5678;
        repeat (3) tick();
        prev = -1; run = 0; seen_chg = 0; wrapped = 0;
        for (int n = 0; n < 40; n++) begin
            idx = -1;
            for (int i = 0; i < 8; i++) if (an0 == ~(8'd1 << i)) idx = i;
            chk("scan_onehot", {31'd0, idx >= 0}, 32'd1);
            if (idx >= 0) begin
                chk("scan_cat", {24'd0, cat0},
                    {24'd0, 1'b1, gl[pc_in[4*idx +: 4]]});
                if (idx != prev) begin
                    if (prev >= 0) begin
                        chk("scan_order", idx, (prev + 1) % 8);
                        if (prev == 7 && idx == 0) wrapped = 1;
                    end
                    if (seen_chg) chk("scan_period", run, 4);
                    if (prev >= 0) seen_chg = 1;
                    run = 1;
                    prev = idx;
                end else begin
                    run++;
                end
            end
            tick();
        end
        chk("scan_wrap", {31'd0, wrapped}, 32'd1);

        view_sel = 3'd6;
        tick();
        chk("lat_old", {31'd0, cat0 == 8'hC0}, 32'd0);
        tick();
        chk("lat_zero", {24'd0, cat0}, 32'hC0);
        view_sel = 3'd7;
        read_disp(0, 3'd7, got);
        chk("view_111", got, 32'h0);

        view_sel = 3'd1;
        repeat (9) tick();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_an", {24'd0, an0}, 32'hFE);
        chk("midrst_cat", {24'd0, cat0}, 32'hC0);
        model_zero();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        read_disp(0, 3'd2, got);
        chk("midrst_cyc", got, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
